// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequences the EX-stage branch comparator, issues redirect/flush and counts branches.
module branch_resolve_ctrl #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 id_is_branch,
  output logic                 id_ready,
  input  logic [2:0]           id_funct3,
  input  logic [WIDTH-1:0]     id_pc,
  input  logic [WIDTH-1:0]     id_imm,
  input  logic [WIDTH-1:0]     rs1_val,
  input  logic [WIDTH-1:0]     rs2_val,
  input  logic                 rs1_pending,
  input  logic                 rs2_pending,
  input  logic                 kill,
  output logic [WIDTH-1:0]     cmp_srcA,
  output logic [WIDTH-1:0]     cmp_srcB,
  output logic [7:0]           cmp_operation,
  input  logic                 cmp_result,
  output logic                 stall,
  output logic                 redirect_valid,
  output logic [WIDTH-1:0]     redirect_target,
  output logic                 flush,
  output logic                 br_illegal,
  output logic [CNT_WIDTH-1:0] cnt_branches,
  output logic [CNT_WIDTH-1:0] cnt_taken
);
  typedef enum logic [1:0] {IDLE, WAIT, EVAL, REDIRECT} state_t;
  state_t state_q, state_d;
  logic [2:0] f3_q, f3_d;
  logic [WIDTH-1:0] pc_q, pc_d, imm_q, imm_d, a_q, a_d, b_q, b_d;
  logic a_ok_q, a_ok_d, b_ok_q, b_ok_d;
  logic [CNT_WIDTH-1:0] cnt_br_q, cnt_br_d, cnt_tk_q, cnt_tk_d;
  logic accept, illegal, taken;
  assign accept  = (state_q == IDLE) & id_valid & id_is_branch & ~kill;
  assign illegal = f3_q[2:1] == 2'b01;
  assign taken   = cmp_result & ~illegal;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_ok_q   <= 1'b0;
      b_ok_q   <= 1'b0;
      cnt_br_q <= '0;
      cnt_tk_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_ok_q   <= a_ok_d;
      b_ok_q   <= b_ok_d;
      cnt_br_q <= cnt_br_d;
      cnt_tk_q <= cnt_tk_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    a_ok_d   = a_ok_q;
    b_ok_d   = b_ok_q;
    cnt_br_d = cnt_br_q;
    cnt_tk_d = cnt_tk_q;
    case (state_q)
      IDLE: if (accept) begin
        f3_d   = id_funct3;
        pc_d   = id_pc;
        imm_d  = id_imm;
        a_ok_d = 1'b0;
        b_ok_d = 1'b0;
        if (rs1_pending | rs2_pending) state_d = WAIT;
        else begin
          a_d     = rs1_val;
          b_d     = rs2_val;
          state_d = EVAL;
        end
      end
      WAIT: begin
        // an operand, once captured, is refreshed while its pending bit stays low
        if (!rs1_pending) begin
          a_d    = rs1_val;
          a_ok_d = 1'b1;
        end
        if (!rs2_pending) begin
          b_d    = rs2_val;
          b_ok_d = 1'b1;
        end
        if ((a_ok_q | ~rs1_pending) & (b_ok_q | ~rs2_pending)) state_d = EVAL;
      end
      EVAL: begin
        state_d  = taken ? REDIRECT : IDLE;
        cnt_br_d = kill ? cnt_br_q : cnt_br_q + CNT_WIDTH'(1);
        cnt_tk_d = (taken & ~kill) ? cnt_tk_q + CNT_WIDTH'(1) : cnt_tk_q;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end
  always_comb begin
    id_ready        = (state_q == IDLE) & ~kill;
    stall           = (state_q == WAIT) | (state_q == EVAL);
    cmp_srcA        = (state_q == EVAL) ? a_q : '0;
    cmp_srcB        = (state_q == EVAL) ? b_q : '0;
    cmp_operation   = (state_q == EVAL) ? {5'b0, f3_q} : 8'h00;
    br_illegal      = (state_q == EVAL) & illegal;
    redirect_valid  = (state_q == REDIRECT) & ~kill;
    flush           = redirect_valid;
    redirect_target = pc_q + imm_q;
    cnt_branches    = cnt_br_q;
    cnt_taken       = cnt_tk_q;
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed vectors with hand-computed expectations for branch_resolve_ctrl.
module tb_branch_resolve_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        id_valid = 1'b0, id_is_branch = 1'b0, id_ready;
  logic [2:0]  id_funct3 = '0;
  logic [31:0] id_pc = '0, id_imm = '0, rs1_val = '0, rs2_val = '0;
  logic        rs1_pending = 1'b0, rs2_pending = 1'b0, kill = 1'b0;
  logic [31:0] cmp_srcA, cmp_srcB, redirect_target, cnt_branches, cnt_taken;
  logic [7:0]  cmp_operation;
  logic        cmp_result, stall, redirect_valid, flush, br_illegal;
  int checks = 0, errors = 0;
  branch_resolve_ctrl #(.WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_ready(id_ready), .id_funct3(id_funct3), .id_pc(id_pc), .id_imm(id_imm),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .kill(kill), .cmp_srcA(cmp_srcA), .cmp_srcB(cmp_srcB), .cmp_operation(cmp_operation),
    .cmp_result(cmp_result), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .flush(flush), .br_illegal(br_illegal),
    .cnt_branches(cnt_branches), .cnt_taken(cnt_taken)
  );
  always #5 clk = ~clk;
  always_comb begin
    case (cmp_operation[2:0])
      3'd0:    cmp_result = cmp_srcA == cmp_srcB;
      3'd1:    cmp_result = cmp_srcA != cmp_srcB;
      3'd4:    cmp_result = $signed(cmp_srcA) < $signed(cmp_srcB);
      3'd5:    cmp_result = $signed(cmp_srcA) >= $signed(cmp_srcB);
      3'd6:    cmp_result = cmp_srcA < cmp_srcB;
      3'd7:    cmp_result = cmp_srcA >= cmp_srcB;
      default: cmp_result = 1'b1;
    endcase
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic issue(input logic [2:0] f3, input logic [31:0] pc, imm, a, b);
    id_valid = 1'b1; id_is_branch = 1'b1; id_funct3 = f3;
    id_pc = pc; id_imm = imm; rs1_val = a; rs2_val = b;
    tick();
    id_valid = 1'b0; id_is_branch = 1'b0;
  endtask
  initial begin
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst id_ready", id_ready, 1);
    chk("rst stall", stall, 0);
    chk("rst redirect", redirect_valid, 0);
    chk("rst flush", flush, 0);
    chk("rst illegal", br_illegal, 0);
    chk("rst target", redirect_target, 0);
    chk("rst srcA", cmp_srcA, 0);
    chk("rst op", cmp_operation, 0);
    chk("rst cnt_br", cnt_branches, 0);
    chk("rst cnt_tk", cnt_taken, 0);
    // BEQ taken
    issue(3'd0, 32'h100, 32'h20, 32'd5, 32'd5);
    chk("beq eval stall", stall, 1);
    chk("beq eval ready", id_ready, 0);
    chk("beq eval op", cmp_operation, 8'h00);
    chk("beq eval srcA", cmp_srcA, 5);
    tick();
    chk("beq redirect", redirect_valid, 1);
    chk("beq flush", flush, 1);
    chk("beq target", redirect_target, 32'h120);
    chk("beq redir stall", stall, 0);
    chk("beq cnt_br", cnt_branches, 1);
    chk("beq cnt_tk", cnt_taken, 1);
    tick();
    chk("beq idle redirect", redirect_valid, 0);
    chk("beq idle ready", id_ready, 1);
    // BLT signed taken
    issue(3'd4, 32'h0, 32'h8, 32'hFFFF_FFFF, 32'd1);
    chk("blt op", cmp_operation, 8'h04);
    tick();
    chk("blt redirect", redirect_valid, 1);
    chk("blt target", redirect_target, 32'h8);
    tick();
    // BLTU not taken
    issue(3'd6, 32'h0, 32'h8, 32'hFFFF_FFFF, 32'd1);
    chk("bltu op", cmp_operation, 8'h06);
    tick();
    chk("bltu redirect", redirect_valid, 0);
    chk("bltu idle ready", id_ready, 1);
    chk("bltu stall", stall, 0);
    chk("bltu cnt_br", cnt_branches, 3);
    chk("bltu cnt_tk", cnt_taken, 2);
    // load-use wait on rs2
    rs2_pending = 1'b1;
    issue(3'd1, 32'h200, 32'h40, 32'd7, 32'hDEAD);
    chk("wait1 stall", stall, 1);
    chk("wait1 op", cmp_operation, 0);
    tick();
    chk("wait2 stall", stall, 1);
    tick();
    rs2_pending = 1'b0; rs2_val = 32'd9;
    chk("wait3 stall", stall, 1);
    chk("wait3 srcB", cmp_srcB, 0);
    tick();
    rs2_val = 32'h55;
    chk("wait eval stall", stall, 1);
    chk("wait eval srcA", cmp_srcA, 7);
    chk("wait eval srcB", cmp_srcB, 9);
    chk("wait eval op", cmp_operation, 8'h01);
    tick();
    chk("wait redirect", redirect_valid, 1);
    chk("wait target", redirect_target, 32'h240);
    chk("wait redir stall", stall, 0);
    tick();
    chk("wait cnt_br", cnt_branches, 4);
    chk("wait cnt_tk", cnt_taken, 3);
    // illegal funct3 = 2
    issue(3'd2, 32'h300, 32'h10, 32'd3, 32'd3);
    chk("ill pulse", br_illegal, 1);
    tick();
    chk("ill pulse end", br_illegal, 0);
    chk("ill redirect", redirect_valid, 0);
    chk("ill cnt_br", cnt_branches, 5);
    chk("ill cnt_tk", cnt_taken, 3);
    // kill in EVAL of a taken branch
    issue(3'd0, 32'h400, 32'h4, 32'd1, 32'd1);
    kill = 1'b1;
    chk("kill eval stall", stall, 1);
    tick();
    chk("kill redirect", redirect_valid, 0);
    chk("kill ready held", id_ready, 0);
    chk("kill cnt_br", cnt_branches, 5);
    chk("kill cnt_tk", cnt_taken, 3);
    kill = 1'b0;
    #1;
    chk("kill idle ready", id_ready, 1);
    chk("kill idle stall", stall, 0);
    // kill blocks accept in IDLE
    id_valid = 1'b1; id_is_branch = 1'b1; kill = 1'b1;
    #1;
    chk("kill idle no ready", id_ready, 0);
    tick();
    id_valid = 1'b0; id_is_branch = 1'b0; kill = 1'b0;
    chk("kill no accept stall", stall, 0);
    tick();
    chk("kill no accept redirect", redirect_valid, 0);
    // non-branch is ignored
    id_valid = 1'b1; id_is_branch = 1'b0;
    tick();
    id_valid = 1'b0;
    chk("nonbranch stall", stall, 0);
    // wrap-around target
    issue(3'd0, 32'hFFFF_FFF0, 32'h20, 32'd2, 32'd2);
    tick();
    chk("wrap redirect", redirect_valid, 1);
    chk("wrap target", redirect_target, 32'h10);
    tick();
    chk("wrap cnt_br", cnt_branches, 6);
    chk("wrap cnt_tk", cnt_taken, 4);
    // reset during WAIT
    rs1_pending = 1'b1;
    issue(3'd0, 32'h500, 32'h8, 32'd4, 32'd4);
    chk("rw wait stall", stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; rs1_pending = 1'b0;
    #1;
    chk("rw stall", stall, 0);
    chk("rw ready", id_ready, 1);
    chk("rw redirect", redirect_valid, 0);
    chk("rw target", redirect_target, 0);
    chk("rw cnt_br", cnt_branches, 0);
    chk("rw cnt_tk", cnt_taken, 0);
    tick();
    chk("rw after redirect", redirect_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
